// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the byte-serial and parallel datapath stages.
//   AES_BLOCK_BYTES : number of bytes in one 128-bit AES state
//   aes_byte_t      : one state byte
//   shift_idx       : source byte index for output byte j of ShiftRows
//   inv_shift_idx   : source byte index for output byte j of InvShiftRows
// Byte index j = 4*column + row (column-major), so j[1:0] is the row and
// j[3:2] is the column.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  // Forward ShiftRows: row r is rotated left by r, so output (r, c) comes
  // from column (c + r) mod 4. The 2-bit column sum wraps on its own.
  function automatic logic [3:0] shift_idx(input logic [3:0] j);
    logic [1:0] row;
    logic [1:0] col;
    row = j[1:0];
    col = j[3:2];
    return {2'(col + row), row};
  endfunction

  // InvShiftRows: row r is rotated right by r, so output (r, c) comes
  // from column (c - r) mod 4.
  function automatic logic [3:0] inv_shift_idx(input logic [3:0] j);
    logic [1:0] row;
    logic [1:0] col;
    row = j[1:0];
    col = j[3:2];
    return {2'(col - row), row};
  endfunction

endpackage

// File: rtl/aes_byte_bank.sv
// ---------------------------------------------------------------------------
// aes_byte_bank
// One 16 x 8-bit register bank with a "full" flag, used as half of a
// ping-pong buffer.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   we, widx, wdata     : byte write (registered)
//   ridx, rdata         : combinational byte read
//   set_full, clr_full  : mark the bank as holding a complete block / empty
//   full                : registered full flag
// ---------------------------------------------------------------------------
module aes_byte_bank
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] widx,
  input  logic [7:0] wdata,
  input  logic [3:0] ridx,
  output logic [7:0] rdata,
  input  logic       set_full,
  input  logic       clr_full,
  output logic       full
);

  aes_byte_t mem [AES_BLOCK_BYTES];

  // Byte storage. Reset wipes the contents so a discarded block can never
  // leak onto the output, and so the read mux shows 0x00 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Full flag. The owner never sets and clears the same bank in one cycle
  // (the writer only targets a non-full bank, the reader only a full one),
  // so the priority between the two requests is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/inv_shiftrows_serial.sv
// ---------------------------------------------------------------------------
// inv_shiftrows_serial
// Byte-serial AES (Inv)ShiftRows stage. A 16-byte state arrives in stream
// order on the input handshake, is captured into one of two banks, and is
// replayed in permuted order on the output handshake while the other bank
// fills, giving one byte per cycle sustained.
// Parameters:
//   INVERSE   : 1 = InvShiftRows order, 0 = forward ShiftRows order
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data      : input byte stream
//   out_valid, out_ready, out_data   : output byte stream
//   out_last                         : marks the 16th output byte of a block
// ---------------------------------------------------------------------------
module inv_shiftrows_serial
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic       wr_bank;
  logic       rd_bank;
  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic [1:0] full;
  logic       wr_fire;
  logic       rd_fire;
  logic       wr_done;
  logic       rd_done;
  logic [3:0] rd_idx;
  aes_byte_t  rdata [2];

  // Handshake flags come straight from the registered full flags, so
  // in_ready never sees out_ready and out_valid never sees in_valid.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_done = wr_fire && (wr_cnt == 4'd15);
  assign rd_done = rd_fire && (rd_cnt == 4'd15);

  // The permutation is applied on the read side: the bank holds bytes in
  // stream order and the read counter is mapped to the source byte.
  assign rd_idx = INVERSE ? inv_shift_idx(rd_cnt) : shift_idx(rd_cnt);

  // Outputs depend only on registers (pointers, counters, bank contents),
  // so they hold steady while the consumer stalls.
  assign out_data = rdata[rd_bank];
  assign out_last = out_valid && (rd_cnt == 4'd15);

  aes_byte_bank u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_fire && !wr_bank),
    .widx     (wr_cnt),
    .wdata    (in_data),
    .ridx     (rd_idx),
    .rdata    (rdata[0]),
    .set_full (wr_done && !wr_bank),
    .clr_full (rd_done && !rd_bank),
    .full     (full[0])
  );

  aes_byte_bank u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_fire && wr_bank),
    .widx     (wr_cnt),
    .wdata    (in_data),
    .ridx     (rd_idx),
    .rdata    (rdata[1]),
    .set_full (wr_done && wr_bank),
    .clr_full (rd_done && rd_bank),
    .full     (full[1])
  );

  // Write side: the 4-bit counter wraps from 15 to 0 by itself, and the
  // bank pointer flips once the 16th byte of a block has been stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 4'd0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) begin
        wr_bank <= !wr_bank;
      end
    end
  end

  // Read side mirrors the write side: after the 16th byte is taken the
  // bank is released (its full flag clears) and reading moves to the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= 4'd0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_cnt == 4'd15) begin
        rd_bank <= !rd_bank;
      end
    end
  end

endmodule
